// File: rtl/random_arbiter.sv
// Round-robin arbiter that shares one LFSR among NUM_REQ requesters and returns
// a value in [0, bound). Define RANDOM_ARB_STATS_EN to add draw/fallback counters.
module random_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int RND_W        = 16,
  parameter int OUT_W        = 8,
  parameter int DECORR_STEPS = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*OUT_W-1:0] bound,
  input  logic [RND_W-1:0]         rnd_in,
  output logic                     lfsr_en,
  output logic [NUM_REQ-1:0]       ack,
  output logic [OUT_W-1:0]         rnd_out,
  output logic                     busy
`ifdef RANDOM_ARB_STATS_EN
  ,
  output logic [15:0]              draw_cnt,
  output logic [15:0]              fallback_cnt
`endif
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STEP_W  = (DECORR_STEPS > 1) ? $clog2(DECORR_STEPS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, STEP, SETTLE, SAMPLE, ACK} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, winner, pick_idx, scan;
  logic               pick_valid;
  logic [OUT_W-1:0]   pick_bound, bound_l, mask, cand;
  logic [STEP_W-1:0]  step_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               accept, at_limit;

  // Only the low OUT_W bits of the LFSR word take part in the reduction.
  logic unused_rnd_hi;
  assign unused_rnd_hi = ^rnd_in;

  // All bits at and below the MSB of v set.
  function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = v;
    for (int i = 0; i < OUT_W; i++) r = r | (r >> 1);
    return r;
  endfunction

  // Round-robin pick: first set request scanning upward from rr_ptr.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    pick_bound = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_valid && req[scan]) begin
        pick_valid = 1'b1;
        pick_idx   = scan;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_bound = bound[i*OUT_W +: OUT_W];
    end
  end

  assign cand     = rnd_in[OUT_W-1:0] & mask;
  assign accept   = cand < bound_l;
  assign at_limit = retry_cnt == RETRY_W'(MAX_RETRY);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lfsr_en   = 1'b0;
    ack       = '0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:   if (pick_valid) state_nxt = STEP;
      STEP: begin
        lfsr_en = 1'b1;
        if (step_cnt == STEP_W'(DECORR_STEPS - 1)) state_nxt = SETTLE;
      end
      // One idle cycle lets the LFSR's registered output catch up.
      SETTLE: state_nxt = SAMPLE;
      SAMPLE: state_nxt = (accept || at_limit) ? ACK : STEP;
      ACK: begin
        ack[winner] = req[winner];
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      winner    <= '0;
      bound_l   <= '0;
      mask      <= '0;
      step_cnt  <= '0;
      retry_cnt <= '0;
      rnd_out   <= '0;
    end else begin
      step_cnt <= (state == STEP && state_nxt == STEP) ? step_cnt + STEP_W'(1) : '0;
      unique case (state)
        IDLE: if (pick_valid) begin
          winner    <= pick_idx;
          bound_l   <= pick_bound;
          mask      <= (pick_bound < OUT_W'(2)) ? '0 : smear(pick_bound - OUT_W'(1));
          retry_cnt <= '0;
        end
        SAMPLE: begin
          if (accept)        rnd_out <= cand;
          // cand <= mask < 2*bound_l, so the difference is already in range.
          else if (at_limit) rnd_out <= (bound_l == '0) ? '0 : cand - bound_l;
          else               retry_cnt <= retry_cnt + RETRY_W'(1);
        end
        ACK: rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        default: ;
      endcase
    end
  end

`ifdef RANDOM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_cnt     <= '0;
      fallback_cnt <= '0;
    end else if (state == SAMPLE) begin
      if (draw_cnt != 16'hFFFF) draw_cnt <= draw_cnt + 16'd1;
      if (!accept && at_limit && fallback_cnt != 16'hFFFF)
        fallback_cnt <= fallback_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_random_arbiter.sv
// Scoreboard bench for random_arbiter: a behavioural model predicts each ack
// (requester, value, cycle); a monitor pops and compares on every ack pulse.
module tb_random_arbiter;
  localparam int NR = 3, RW = 16, OW = 8, DS = 4, MR = 3, NW = 8192;

  logic clk = 1'b0, rst;
  logic [NR-1:0]    req;
  logic [NR*OW-1:0] bound;
  logic [RW-1:0]    rnd_in;
  logic             lfsr_en, busy;
  logic [NR-1:0]    ack;
  logic [OW-1:0]    rnd_out;
`ifdef RANDOM_ARB_STATS_EN
  logic [15:0] draw_cnt, fallback_cnt;
`endif

  random_arbiter #(.NUM_REQ(NR), .RND_W(RW), .OUT_W(OW), .DECORR_STEPS(DS), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .req(req), .bound(bound), .rnd_in(rnd_in),
    .lfsr_en(lfsr_en), .ack(ack), .rnd_out(rnd_out), .busy(busy)
`ifdef RANDOM_ARB_STATS_EN
    , .draw_cnt(draw_cnt), .fallback_cnt(fallback_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Registered random source: advances one word per enabled clock.
  logic [RW-1:0] words [NW];
  int   lidx = 0, cyc = 0;
  logic en_s = 1'b0;
  always @(negedge clk) en_s <= lfsr_en;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en_s) lidx <= lidx + 1;
  end
  assign rnd_in = words[lidx % NW];

  typedef struct { int idx; logic [OW-1:0] val; int cyc; } exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0;
  int model_ptr = 0, exp_fb = 0, exp_draws = 0;
  logic [OW-1:0] bnd [NR];
  logic [NR-1:0] rv;
  int base, idle_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Smallest 2^m-1 covering bound-1; zero for bounds 0 and 1.
  function automatic int mask_of(input int b);
    int m = 1;
    if (b < 2) return 0;
    while (m < b) m = m * 2;
    return m - 1;
  endfunction

  task automatic model_draw(input int b, input int start, output int rej, output int val, output int fb);
    int cand;
    bit done = 0;
    rej = 0; val = 0; fb = 0; cand = 0;
    for (int k = 0; k <= MR; k++) begin
      if (!done) begin
        cand = int'(words[(start + DS * (k + 1)) % NW][OW-1:0]) & mask_of(b);
        rej  = k;
        if (cand < b) begin val = cand; done = 1; end
      end
    end
    if (!done) begin
      fb  = 1;
      val = (b == 0) ? 0 : cand - b;
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, " drain timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  // Hold requests rv with bounds bnd[] for n draws; predict all acks up front.
  task automatic run_batch(input logic [NR-1:0] r, input int n, input string tag);
    int t, b0, ptr, w, rej, val, fb;
    exp_t e;
    @(negedge clk);
    check({tag, " idle busy"}, busy, 0);
    t = cyc; b0 = lidx; ptr = model_ptr;
    for (int d = 0; d < n; d++) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && r[(ptr + k) % NR]) w = (ptr + k) % NR;
      model_draw(int'(bnd[w]), b0, rej, val, fb);
      e.idx = w; e.val = OW'(val); e.cyc = t + DS + 3 + (DS + 2) * rej;
      sb.push_back(e);
      b0 += DS * (rej + 1);
      ptr = (w + 1) % NR;
      t   = e.cyc + 1;
      exp_fb += fb; exp_draws += rej + 1;
    end
    model_ptr = ptr;
    for (int i = 0; i < NR; i++) bound[i*OW +: OW] = bnd[i];
    req = r;
    wait_drain(n * 40 + 20, tag);
    #1 req = '0;
    check({tag, " lfsr steps"}, lidx, b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack != '0) begin
      if (sb.size() == 0) check("unexpected ack", ack, 0);
      else begin
        e = sb.pop_front();
        check("ack onehot", ack, 32'(1) << e.idx);
        check("rnd_out", rnd_out, e.val);
        check("ack cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NW; i++) words[i] = RW'($urandom);
    rst = 1'b1; req = '0; bound = '0;
    for (int i = 0; i < NR; i++) bnd[i] = '0;
    repeat (3) @(negedge clk);
    check("rst lfsr_en", lfsr_en, 0);
    check("rst ack", ack, 0);
    check("rst busy", busy, 0);
    check("rst rnd_out", rnd_out, 0);
    rst = 1'b0;

    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (lfsr_en !== 1'b0 || ack !== '0 || busy !== 1'b0 || rnd_out !== '0) idle_bad++;
    end
    check("idle quiet cycles", idle_bad, 0);

    // Single draw, bound 16, word low byte 0x2B -> 0x0B; bound change mid-draw ignored.
    words[(lidx + DS) % NW][7:0] = 8'h2B;
    bnd[1] = 8'd16;
    fork
      begin
        repeat (3) @(negedge clk);
        bound[OW +: OW] = 8'd3;
      end
    join_none
    run_batch(3'b010, 1, "pow2");
    repeat (3) @(negedge clk);
    check("rnd_out hold", rnd_out, 8'h0B);

    // bound 10, every sample's low nibble 0xC -> three retries then fallback 2.
    for (int k = 1; k <= MR + 1; k++)
      words[(lidx + DS * k) % NW][3:0] = 4'hC;
    bnd[0] = 8'd10;
    run_batch(3'b001, 1, "fallback");
`ifdef RANDOM_ARB_STATS_EN
    check("fallback_cnt", fallback_cnt, exp_fb);
`endif

    bnd[2] = 8'd0; run_batch(3'b100, 1, "bound0");
    bnd[2] = 8'd1; run_batch(3'b100, 1, "bound1");

    // Abort: requester 0 drops mid-draw; no ack, but the pointer still advances.
    @(negedge clk);
    base = lidx;
    bound[0 +: OW] = 8'd16;
    req = 3'b001;
    repeat (3) @(negedge clk);
    req = '0;
    repeat (12) @(negedge clk);
    check("abort lfsr steps", lidx, base + DS);
    check("abort busy", busy, 0);
    model_ptr = 1; exp_draws += 1;
    bnd[0] = 8'd7; bnd[1] = 8'd5;
    run_batch(3'b011, 1, "after abort");

    // Reset during STEP: enable drops immediately, pointer returns to 0.
    @(negedge clk);
    bound[2*OW +: OW] = 8'd50;
    req = 3'b100;
    repeat (2) @(negedge clk);
    check("step lfsr_en", lfsr_en, 1);
    rst = 1'b1;
    #1;
    check("async rst lfsr_en", lfsr_en, 0);
    check("async rst busy", busy, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0; exp_fb = 0; exp_draws = 0;
    for (int i = 0; i < NR; i++) bnd[i] = 8'd8;
    run_batch(3'b111, 4, "round robin");

    for (int it = 0; it < 12; it++) begin
      rv = NR'($urandom_range(1, 7));
      for (int i = 0; i < NR; i++)
        bnd[i] = ($urandom_range(0, 3) == 0) ? OW'(1 << $urandom_range(0, 7))
                                              : OW'($urandom_range(0, 255));
      run_batch(rv, int'($urandom_range(1, 5)), $sformatf("rand%0d", it));
      repeat (2) @(negedge clk);
    end

`ifdef RANDOM_ARB_STATS_EN
    check("draw_cnt", draw_cnt, exp_draws);
    check("fallback_cnt end", fallback_cnt, exp_fb);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
